// File: rtl/oci_dct_pkg.sv
// Shared types and constants for the OCI data-compression-trace buffer sequencer.
package oci_dct_pkg;

    localparam int ATOM_W = 2;
    localparam int SLOTS  = 15;
    localparam int CNT_W  = 4;
    localparam int BUF_W  = ATOM_W * SLOTS;

    typedef logic [BUF_W-1:0]  dct_buf_t;
    typedef logic [CNT_W-1:0]  dct_cnt_t;
    typedef logic [ATOM_W-1:0] dct_atom_t;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        END_FLUSH = 2'd1,
        END_DRAIN = 2'd2,
        ENDED     = 2'd3
    } end_state_e;

    // Writes one atom into the given slot; an out-of-range slot leaves the buffer untouched.
    function automatic dct_buf_t put_atom(dct_buf_t buf_in, dct_cnt_t slot, dct_atom_t atom);
        dct_buf_t r;
        r = buf_in;
        for (int i = 0; i < SLOTS; i++) begin
            if (slot == dct_cnt_t'(i)) begin
                r[i*ATOM_W +: ATOM_W] = atom;
            end else begin
                r[i*ATOM_W +: ATOM_W] = buf_in[i*ATOM_W +: ATOM_W];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/oci_dct_frame_reg.sv
// Output frame register: holds a frame under backpressure and counts accepted frames.
module oci_dct_frame_reg
    import oci_dct_pkg::*;
#(
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  dct_buf_t          load_data,
    input  dct_cnt_t          load_count,
    input  logic              frame_ready,
    output logic              frame_valid,
    output dct_buf_t          frame_data,
    output dct_cnt_t          frame_count,
    output logic [FCNT_W-1:0] frames_emitted,
    output logic              slot_free
);

    logic              frame_valid_q, frame_valid_d;
    dct_buf_t          frame_data_q, frame_data_d;
    dct_cnt_t          frame_count_q, frame_count_d;
    logic [FCNT_W-1:0] frames_emitted_q, frames_emitted_d;
    logic              handshake_s;

    assign handshake_s = frame_valid_q && frame_ready;
    // A new load may replace a frame only when the sink takes the old one this cycle.
    assign slot_free   = !frame_valid_q || frame_ready;

    // Next-state for the output register and emitted-frame counter.
    always_comb begin
        frame_valid_d    = frame_valid_q;
        frame_data_d     = frame_data_q;
        frame_count_d    = frame_count_q;
        frames_emitted_d = frames_emitted_q;
        if (load) begin
            frame_valid_d = 1'b1;
            frame_data_d  = load_data;
            frame_count_d = load_count;
        end else if (handshake_s) begin
            frame_valid_d = 1'b0;
        end else begin
            frame_valid_d = frame_valid_q;
        end
        if (handshake_s) begin
            frames_emitted_d = frames_emitted_q + {{(FCNT_W-1){1'b0}}, 1'b1};
        end else begin
            frames_emitted_d = frames_emitted_q;
        end
    end

    // Output register state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_valid_q    <= 1'b0;
            frame_data_q     <= '0;
            frame_count_q    <= '0;
            frames_emitted_q <= '0;
        end else begin
            frame_valid_q    <= frame_valid_d;
            frame_data_q     <= frame_data_d;
            frame_count_q    <= frame_count_d;
            frames_emitted_q <= frames_emitted_d;
        end
    end

    assign frame_valid    = frame_valid_q;
    assign frame_data     = frame_data_q;
    assign frame_count    = frame_count_q;
    assign frames_emitted = frames_emitted_q;

endmodule

// File: rtl/oci_dct_pack_ctrl.sv
// Packs 2-bit trace atoms into a 30-bit live buffer, hands full/flushed buffers downstream,
// and runs the end-of-test drain that raises test_has_ended.
module oci_dct_pack_ctrl
    import oci_dct_pkg::*;
#(
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              atom_valid,
    input  logic [ATOM_W-1:0] atom_data,
    output logic              atom_ready,
    input  logic              flush_req,
    input  logic              test_ending,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic [BUF_W-1:0]  frame_data,
    output logic [CNT_W-1:0]  frame_count,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              test_has_ended,
    output logic [FCNT_W-1:0] frames_emitted
);

    end_state_e state_q, state_d;
    dct_buf_t   dct_buffer_q, dct_buffer_d;
    dct_cnt_t   dct_count_q, dct_count_d;
    logic       flush_pending_q, flush_pending_d;
    logic       ended_q, ended_d;
    logic       ready_en_q;

    dct_buf_t   base_buf_s;
    dct_cnt_t   base_cnt_s;
    logic       full_s, nonempty_s, atom_ready_s, accept_s, xfer_s;
    logic       slot_free_s, frame_valid_s;

    assign full_s       = (dct_count_q == dct_cnt_t'(SLOTS));
    assign nonempty_s   = (dct_count_q != dct_cnt_t'(0));
    // ready_en_q keeps atom_ready low while reset is asserted, as the reset state is RUN.
    assign atom_ready_s = ready_en_q && (state_q == RUN) && (dct_count_q < dct_cnt_t'(SLOTS));
    assign accept_s     = atom_valid && atom_ready_s;
    assign xfer_s       = (full_s || flush_pending_q || (state_q == END_FLUSH))
                          && nonempty_s && slot_free_s;

    // Packer, flush tracking and end-of-test sequencing.
    always_comb begin
        base_buf_s      = dct_buffer_q;
        base_cnt_s      = dct_count_q;
        dct_buffer_d    = dct_buffer_q;
        dct_count_d     = dct_count_q;
        flush_pending_d = flush_pending_q;
        state_d         = state_q;

        if (xfer_s) begin
            base_buf_s = '0;
            base_cnt_s = dct_cnt_t'(0);
        end else begin
            base_buf_s = dct_buffer_q;
            base_cnt_s = dct_count_q;
        end

        if (accept_s) begin
            dct_buffer_d = put_atom(base_buf_s, base_cnt_s, atom_data);
            dct_count_d  = base_cnt_s + dct_cnt_t'(1);
        end else begin
            dct_buffer_d = base_buf_s;
            dct_count_d  = base_cnt_s;
        end

        // A flush arriving with the transfer applies to the old buffer, not the new one.
        if (xfer_s) begin
            flush_pending_d = 1'b0;
        end else if (flush_req && nonempty_s) begin
            flush_pending_d = 1'b1;
        end else begin
            flush_pending_d = flush_pending_q;
        end

        case (state_q)
            RUN:       state_d = test_ending ? END_FLUSH : RUN;
            END_FLUSH: state_d = nonempty_s ? END_FLUSH : END_DRAIN;
            END_DRAIN: state_d = frame_valid_s ? END_DRAIN : ENDED;
            ENDED:     state_d = ENDED;
            default:   state_d = RUN;
        endcase

        ended_d = (state_d == ENDED);
    end

    // Live buffer, FSM and sticky end flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= RUN;
            dct_buffer_q    <= '0;
            dct_count_q     <= dct_cnt_t'(0);
            flush_pending_q <= 1'b0;
            ended_q         <= 1'b0;
            ready_en_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            dct_buffer_q    <= dct_buffer_d;
            dct_count_q     <= dct_count_d;
            flush_pending_q <= flush_pending_d;
            ended_q         <= ended_d;
            ready_en_q      <= 1'b1;
        end
    end

    oci_dct_frame_reg #(
        .FCNT_W (FCNT_W)
    ) u_frame_reg (
        .clk            (clk),
        .reset_n        (reset_n),
        .load           (xfer_s),
        .load_data      (dct_buffer_q),
        .load_count     (dct_count_q),
        .frame_ready    (frame_ready),
        .frame_valid    (frame_valid_s),
        .frame_data     (frame_data),
        .frame_count    (frame_count),
        .frames_emitted (frames_emitted),
        .slot_free      (slot_free_s)
    );

    assign atom_ready     = atom_ready_s;
    assign frame_valid    = frame_valid_s;
    assign dct_buffer     = dct_buffer_q;
    assign dct_count      = dct_count_q;
    assign test_has_ended = ended_q;

endmodule

// File: tb/tb_oci_dct_pack_ctrl.sv
// Scoreboard bench: frames are predicted as ordered groups of accepted atoms and checked on handshake.
module tb_oci_dct_pack_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        atom_valid, flush_req, test_ending, frame_ready;
    logic [1:0]  atom_data;
    logic        atom_ready, frame_valid, test_has_ended;
    logic [29:0] frame_data, dct_buffer;
    logic [3:0]  frame_count, dct_count;
    logic [15:0] frames_emitted;

    typedef struct {
        logic [29:0] data;
        logic [3:0]  cnt;
    } frame_t;

    frame_t     exp_q[$];
    logic [1:0] cur[$];
    frame_t     mon_e;
    logic       model_ended;
    int         checks = 0;
    int         errors = 0;
    int         hs_count = 0;

    always #5 clk = ~clk;

    oci_dct_pack_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .atom_valid(atom_valid), .atom_data(atom_data), .atom_ready(atom_ready),
        .flush_req(flush_req), .test_ending(test_ending),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_data(frame_data), .frame_count(frame_count),
        .dct_buffer(dct_buffer), .dct_count(dct_count),
        .test_has_ended(test_has_ended), .frames_emitted(frames_emitted)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic void push_frame();
        frame_t f;
        f.data = '0;
        f.cnt  = 4'(cur.size());
        foreach (cur[i]) f.data = f.data | (30'(cur[i]) << (2 * i));
        exp_q.push_back(f);
        cur.delete();
    endfunction

    // Reference model: 15 accepted atoms form a frame; an idle flush or test end cuts a partial one.
    always @(negedge clk) begin
        if (reset_n) begin
            if (atom_valid && atom_ready) begin
                cur.push_back(atom_data);
                if (cur.size() == 15) push_frame();
            end else if ((flush_req || test_ending) && !model_ended && cur.size() > 0) begin
                push_frame();
            end
            if (test_ending) model_ended = 1'b1;
        end
    end

    // Monitor: every handshake must match the oldest predicted frame.
    always @(negedge clk) begin
        if (reset_n && frame_valid && frame_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL frame_unexpected actual=%0h/%0d expected=none", frame_data, frame_count);
            end else begin
                mon_e = exp_q.pop_front();
                if (frame_data !== mon_e.data || frame_count !== mon_e.cnt) begin
                    errors++;
                    $display("FAIL frame_content actual=%0h/%0d expected=%0h/%0d",
                             frame_data, frame_count, mon_e.data, mon_e.cnt);
                end
            end
            hs_count++;
        end
    end

    // Holds atom_valid until accepted; caller drops atom_valid afterwards.
    task automatic send_atom(input logic [1:0] d, output int waited);
        atom_valid = 1'b1;
        atom_data  = d;
        waited     = 0;
        forever begin
            @(negedge clk);
            waited++;
            if (atom_ready) break;
            if (waited > 200) begin
                chk("send_atom_timeout", 64'(waited), 64'd0);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic send_n(input int n, input bit pattern);
        int w;
        for (int i = 0; i < n; i++) send_atom(pattern ? 2'(i % 4) : 2'($urandom), w);
        atom_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_atom_ready"},  64'(atom_ready), 64'd0);
        chk({tag, "_frame_valid"}, 64'(frame_valid), 64'd0);
        chk({tag, "_frame_data"},  64'(frame_data), 64'd0);
        chk({tag, "_frame_count"}, 64'(frame_count), 64'd0);
        chk({tag, "_dct_buffer"},  64'(dct_buffer), 64'd0);
        chk({tag, "_dct_count"},   64'(dct_count), 64'd0);
        chk({tag, "_ended"},       64'(test_has_ended), 64'd0);
        chk({tag, "_emitted"},     64'(frames_emitted), 64'd0);
    endtask

    task automatic pulse_reset(input string tag);
        @(posedge clk); #2;
        reset_n = 1'b0;
        cur.delete();
        exp_q.delete();
        model_ended = 1'b0;
        hs_count = 0;
        #1;
        check_zero(tag);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int w, tot, acc, got;
        reset_n = 1'b0; atom_valid = 1'b0; atom_data = 2'd0;
        flush_req = 1'b0; test_ending = 1'b0; frame_ready = 1'b1;
        model_ended = 1'b0;
        #3;
        check_zero("rst");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 15 atoms back-to-back, slot k = k mod 4.
        tot = 0;
        for (int i = 0; i < 15; i++) begin
            send_atom(2'(i % 4), w);
            tot += w;
        end
        atom_valid = 1'b0;
        chk("t1_b2b_cycles", 64'(tot), 64'd15);
        @(negedge clk);
        chk("t1_ready_low", 64'(atom_ready), 64'd0);
        chk("t1_valid_early", 64'(frame_valid), 64'd0);
        chk("t1_dct_full", 64'(dct_count), 64'd15);
        @(negedge clk);
        chk("t1_valid", 64'(frame_valid), 64'd1);
        chk("t1_ready_back", 64'(atom_ready), 64'd1);
        chk("t1_data", 64'(frame_data), 64'h24E4E4E4);
        chk("t1_count", 64'(frame_count), 64'd15);
        @(negedge clk);
        chk("t1_emitted", 64'(frames_emitted), 64'd1);
        @(posedge clk); #1;

        // Partial flush of atoms 2,1,3.
        send_atom(2'd2, w); send_atom(2'd1, w); send_atom(2'd3, w);
        atom_valid = 1'b0;
        pulse_flush();
        @(negedge clk);
        @(negedge clk);
        chk("t2_valid", 64'(frame_valid), 64'd1);
        chk("t2_count", 64'(frame_count), 64'd3);
        chk("t2_data", 64'(frame_data), 64'h36);
        chk("t2_dct_count", 64'(dct_count), 64'd0);
        @(posedge clk); #1;

        // Flush of an empty buffer is dropped.
        repeat (3) @(posedge clk);
        #1;
        pulse_flush();
        repeat (6) @(negedge clk);
        chk("t3_no_frame", 64'(frame_valid), 64'd0);
        chk("t3_emitted", 64'(frames_emitted), 64'd2);
        @(posedge clk); #1;

        // Backpressure: 31 atoms offered with the sink stalled.
        frame_ready = 1'b0;
        atom_valid  = 1'b1;
        atom_data   = 2'($urandom);
        acc = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (atom_ready) acc++;
            @(posedge clk); #1;
            atom_data = 2'($urandom);
        end
        chk("bp_accepted", 64'(acc), 64'd30);
        chk("bp_ready_low", 64'(atom_ready), 64'd0);
        chk("bp_dct_count", 64'(dct_count), 64'd15);
        chk("bp_hold_valid", 64'(frame_valid), 64'd1);
        chk("bp_hold_count", 64'(frame_count), 64'd15);
        if (exp_q.size() > 0) chk("bp_hold_data", 64'(frame_data), 64'(exp_q[0].data));
        else chk("bp_model_frames", 64'(exp_q.size()), 64'd2);
        frame_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got == 0; c++) begin
            @(negedge clk);
            if (atom_ready) got = 1;
            @(posedge clk); #1;
        end
        atom_valid = 1'b0;
        chk("bp_31st_accepted", 64'(got), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        pulse_flush();
        repeat (4) @(posedge clk);
        #1;
        chk("bp_emitted", 64'(frames_emitted), 64'd5);

        // Randomized traffic with random sink backpressure.
        for (int c = 0; c < 400; c++) begin
            atom_valid  = 1'($urandom_range(0, 1));
            atom_data   = 2'($urandom);
            frame_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        atom_valid = 1'b0;
        frame_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        pulse_flush();
        repeat (5) @(posedge clk);
        #1;
        chk("rnd_drained", 64'(exp_q.size()), 64'd0);
        chk("rnd_emitted", 64'(frames_emitted), 64'(16'(hs_count)));

        // End-of-test drain with 5 buffered atoms.
        send_n(5, 1'b0);
        test_ending = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("end_ready_low", 64'(atom_ready), 64'd0);
        @(negedge clk);
        chk("end_frame_count", 64'(frame_count), 64'd5);
        @(negedge clk);
        @(negedge clk);
        chk("end_has_ended", 64'(test_has_ended), 64'd1);
        @(posedge clk); #1;
        test_ending = 1'b0;
        atom_valid  = 1'b1;
        repeat (5) @(negedge clk);
        chk("end_sticky", 64'(test_has_ended), 64'd1);
        chk("end_ready_stays_low", 64'(atom_ready), 64'd0);
        chk("end_drained", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
        atom_valid = 1'b0;

        // Reset mid-fill, then reset with a held frame, then resume.
        pulse_reset("rst_end");
        send_n(7, 1'b0);
        @(negedge clk);
        chk("mid_count7", 64'(dct_count), 64'd7);
        pulse_reset("rst_mid");
        frame_ready = 1'b0;
        send_n(15, 1'b0);
        repeat (3) @(negedge clk);
        chk("mid_frame_held", 64'(frame_valid), 64'd1);
        pulse_reset("rst_frame");
        frame_ready = 1'b1;
        send_n(15, 1'b1);
        repeat (5) @(negedge clk);
        chk("resume_emitted", 64'(frames_emitted), 64'd1);
        chk("resume_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
